// File: rtl/hdng_nav_ctrl_pkg.sv
// Shared types and default tuning for the heading/move command sequencer.
package hdng_nav_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdng,
      StRampUp,
      StCruise,
      StRampDn,
      StDone
   } nav_state_t;

   localparam logic [10:0] MAX_SPD_DEF    = 11'h2A0;
   localparam logic [10:0] SPD_INC_DEF    = 11'h018;
   localparam int unsigned SETTLE_CNT_DEF = 3;

   // Ramp step actually applied; simulation builds use an 8x larger step.
   function automatic logic [10:0] eff_inc(input bit fast_sim, input logic [10:0] inc);
      return fast_sim ? {inc[7:0], 3'b000} : inc;
   endfunction

endpackage

// File: rtl/hdng_nav_ctrl_if.sv
// Command/solver side and PID side signals of the navigation sequencer.
interface hdng_nav_ctrl_if;

   logic        strt_hdng;
   logic        strt_mv;
   logic [11:0] cmd_hdng;
   logic        stp_lft;
   logic        stp_rght;
   logic        lft_opn;
   logic        rght_opn;
   logic        frwrd_opn;
   logic        hdng_vld;
   logic        at_hdng;
   logic [11:0] dsrd_hdng;
   logic [10:0] frwrd_spd;
   logic        moving;
   logic        mv_cmplt;
   logic        busy;

   // Command source / environment side.
   modport master (
      output strt_hdng, strt_mv, cmd_hdng, stp_lft, stp_rght,
      output lft_opn, rght_opn, frwrd_opn, hdng_vld, at_hdng,
      input  dsrd_hdng, frwrd_spd, moving, mv_cmplt, busy
   );

   // Sequencer side.
   modport slave (
      input  strt_hdng, strt_mv, cmd_hdng, stp_lft, stp_rght,
      input  lft_opn, rght_opn, frwrd_opn, hdng_vld, at_hdng,
      output dsrd_hdng, frwrd_spd, moving, mv_cmplt, busy
   );

endinterface

// File: rtl/hdng_nav_ctrl_spd_ramp.sv
// Saturating 11-bit forward speed register with up/down/emergency steps.
module hdng_nav_ctrl_spd_ramp
   import hdng_nav_ctrl_pkg::*;
#(
   parameter logic [10:0] MAX_SPD = MAX_SPD_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   input  logic        dec,
   input  logic        emerg,
   input  logic [10:0] step,
   output logic [10:0] spd,
   output logic        at_max,
   output logic        at_zero
);

   logic [10:0] spd_q, spd_d;
   logic [12:0] sum;
   logic [12:0] dec_amt;

   // Next speed: widened arithmetic so neither ramp direction can wrap.
   always_comb begin
      sum     = {2'b00, spd_q} + {2'b00, step};
      dec_amt = emerg ? {step, 2'b00} : {2'b00, step};
      spd_d   = spd_q;
      if (clr) begin
         spd_d = '0;
      end else if (inc) begin
         spd_d = (sum > {2'b00, MAX_SPD}) ? MAX_SPD : sum[10:0];
      end else if (dec) begin
         spd_d = ({2'b00, spd_q} > dec_amt) ? (spd_q - dec_amt[10:0]) : '0;
      end
   end

   // Speed register.
   always_ff @(posedge clk) begin
      if (rst) spd_q <= '0;
      else     spd_q <= spd_d;
   end

   assign spd     = spd_q;
   assign at_max  = (spd_q == MAX_SPD);
   assign at_zero = (spd_q == 11'd0);

endmodule

// File: rtl/hdng_nav_ctrl.sv
// Command sequencer between the maze solver and the heading PID.
module hdng_nav_ctrl
   import hdng_nav_ctrl_pkg::*;
#(
   parameter bit          FAST_SIM   = 1'b0,
   parameter logic [10:0] MAX_SPD    = MAX_SPD_DEF,
   parameter logic [10:0] SPD_INC    = SPD_INC_DEF,
   parameter int unsigned SETTLE_CNT = SETTLE_CNT_DEF
) (
   input logic            clk,
   input logic            rst,
   hdng_nav_ctrl_if.slave nav
);

   localparam int unsigned CntW = $clog2(SETTLE_CNT + 1);
   localparam logic [10:0] Inc  = eff_inc(FAST_SIM, SPD_INC);

   nav_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [11:0]     dsrd_q, dsrd_d;
   logic            lft_prev_q, rght_prev_q;
   logic            moving_q, mv_cmplt_q, busy_q;
   logic            stop, spd_inc, spd_dec, spd_clr;
   logic            at_max, at_zero;
   logic [10:0]     spd;

   assign stop = (nav.stp_lft  & nav.lft_opn  & ~lft_prev_q) |
                 (nav.stp_rght & nav.rght_opn & ~rght_prev_q);

   // Next-state, settle counter and speed-ramp controls.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dsrd_d  = dsrd_q;
      spd_inc = 1'b0;
      spd_dec = 1'b0;
      spd_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            spd_clr = 1'b1;
            cnt_d   = '0;
            if (nav.strt_hdng) begin
               dsrd_d  = nav.cmd_hdng;
               state_d = StHdng;
            end else if (nav.strt_mv) begin
               state_d = StRampUp;
            end
         end
         StHdng: begin
            if (nav.hdng_vld) begin
               if (!nav.at_hdng) begin
                  cnt_d = '0;
               end else if (cnt_q == CntW'(SETTLE_CNT - 1)) begin
                  // This sample completes the settle run.
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StRampUp: begin
            if (!nav.frwrd_opn || stop) begin
               state_d = StRampDn;
            end else begin
               spd_inc = nav.hdng_vld;
               if (at_max) state_d = StCruise;
            end
         end
         StCruise: begin
            if (!nav.frwrd_opn || stop) state_d = StRampDn;
         end
         StRampDn: begin
            if (at_zero) state_d = StDone;
            else         spd_dec = nav.hdng_vld;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, counter, latched heading, edge history and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         dsrd_q      <= '0;
         lft_prev_q  <= 1'b0;
         rght_prev_q <= 1'b0;
         moving_q    <= 1'b0;
         mv_cmplt_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dsrd_q      <= dsrd_d;
         lft_prev_q  <= nav.lft_opn;
         rght_prev_q <= nav.rght_opn;
         moving_q    <= (state_d != StIdle) && (state_d != StDone);
         mv_cmplt_q  <= (state_d == StDone);
         busy_q      <= (state_d != StIdle);
      end
   end

   hdng_nav_ctrl_spd_ramp #(
      .MAX_SPD (MAX_SPD)
   ) u_spd_ramp (
      .clk     (clk),
      .rst     (rst),
      .clr     (spd_clr),
      .inc     (spd_inc),
      .dec     (spd_dec),
      .emerg   (~nav.frwrd_opn),
      .step    (Inc),
      .spd     (spd),
      .at_max  (at_max),
      .at_zero (at_zero)
   );

   assign nav.dsrd_hdng = dsrd_q;
   assign nav.frwrd_spd = spd;
   assign nav.moving    = moving_q;
   assign nav.mv_cmplt  = mv_cmplt_q;
   assign nav.busy      = busy_q;

endmodule
